// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared RV32I out-of-order types: dispatched instruction,
//                decoded control word, branch funct3 codes and the branch
//                reservation-station entry.
//  Revision    : 1.0  initial release
// ============================================================================
package rv32i_types;

    // Widest physical tag any RS instance may use; narrower tags are zero-extended.
    localparam int c_RS_TAG_W = 8;

    // Branch funct3 encodings (cmp_op).
    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    // Control-transfer opcodes handled by the branch RS.
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } ooo_instr_t;

    typedef struct packed {
        logic [2:0] cmp_op;
        logic       is_jump;
    } ctrl_word_t;

    typedef struct packed {
        ooo_instr_t              instr;
        ctrl_word_t              ctrl;
        logic [c_RS_TAG_W-1:0]   rs1_tag;
        logic [c_RS_TAG_W-1:0]   rs2_tag;
        logic                    rs1_rdy;
        logic                    rs2_rdy;
        logic                    valid;
    } rs_entry_t;

    localparam rs_entry_t c_RS_EMPTY = '0;

    // An entry may issue once it holds both operand values.
    function automatic logic entry_ready(input rs_entry_t e);
        return e.valid && e.rs1_rdy && e.rs2_rdy;
    endfunction

endpackage
`default_nettype wire

// File: rtl/br_rs_select.sv
`default_nettype none
// ============================================================================
//  Module      : br_rs_select
//  Description : Oldest-first priority encoder over the RS ready vector.
//                Slot 0 is the oldest entry, so the lowest set bit wins.
//  Revision    : 1.0  initial release
// ============================================================================
module br_rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         req,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     found
);
    localparam int IDX_W = $clog2(DEPTH);

    // Scan from youngest to oldest so the oldest requester is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/br_rs.sv
`default_nettype none
// ============================================================================
//  Module      : br_rs
//  Description : Branch reservation station. Age-ordered collapsing queue
//                with CDB wakeup, dispatch-time CDB bypass, oldest-ready
//                selection and a single registered issue stage.
//  Revision    : 1.0  initial release
// ============================================================================
module br_rs
    import rv32i_types::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  ooo_instr_t               disp_instr,
    input  ctrl_word_t               disp_ctrl,
    input  logic [TAG_W-1:0]         disp_rs1_tag,
    input  logic [TAG_W-1:0]         disp_rs2_tag,
    input  logic                     disp_rs1_rdy,
    input  logic                     disp_rs2_rdy,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [31:0]              cdb_data,
    output logic                     iss_valid,
    output ooo_instr_t               iss_instr,
    output ctrl_word_t               iss_ctrl,
    input  logic                     iss_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    // TAG_W must not exceed c_RS_TAG_W; stored tags are zero-extended.
    rs_entry_t              r_ent   [DEPTH];
    rs_entry_t              w_woken [DEPTH];
    rs_entry_t              w_col   [DEPTH];
    rs_entry_t              w_next  [DEPTH];
    rs_entry_t              w_disp_ent;
    logic [DEPTH-1:0]       w_rdy_vec;
    logic [IDX_W-1:0]       w_sel_idx;
    logic                   w_found;
    logic [OCC_W-1:0]       r_occ;
    logic [OCC_W-1:0]       w_occ_rem;
    logic [OCC_W-1:0]       w_occ_next;
    logic                   w_out_load;
    logic                   w_issue;
    logic                   w_disp_fire;
    logic [c_RS_TAG_W-1:0]  w_cdb_tag_ext;
    logic                   r_iss_valid;
    ooo_instr_t             r_iss_instr;
    ctrl_word_t             r_iss_ctrl;

    assign w_cdb_tag_ext = c_RS_TAG_W'(cdb_tag);

    // Credit comes only from registered occupancy, never from a same-cycle issue.
    assign disp_ready  = (r_occ < OCC_W'(DEPTH)) && !flush;
    assign w_disp_fire = disp_valid && disp_ready;
    assign w_out_load  = !r_iss_valid || iss_ready;
    assign w_issue     = w_found && w_out_load;
    assign w_occ_rem   = r_occ - {{IDX_W{1'b0}}, w_issue};
    assign w_occ_next  = w_occ_rem + {{IDX_W{1'b0}}, w_disp_fire};

    // Selection looks at registered readiness, so a wakeup costs one cycle.
    always_comb begin
        w_rdy_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy_vec[i] = entry_ready(r_ent[i]);
        end
    end

    br_rs_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .req   (w_rdy_vec),
        .idx   (w_sel_idx),
        .found (w_found)
    );

    // CDB wakeup of held entries waiting on the broadcast tag.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_woken[i] = r_ent[i];
            if (cdb_valid && r_ent[i].valid) begin
                if (!r_ent[i].rs1_rdy && (r_ent[i].rs1_tag == w_cdb_tag_ext)) begin
                    w_woken[i].rs1_rdy        = 1'b1;
                    w_woken[i].instr.rs1_data = cdb_data;
                end
                if (!r_ent[i].rs2_rdy && (r_ent[i].rs2_tag == w_cdb_tag_ext)) begin
                    w_woken[i].rs2_rdy        = 1'b1;
                    w_woken[i].instr.rs2_data = cdb_data;
                end
            end
        end
    end

    // Incoming entry, capturing a same-cycle broadcast for a pending source.
    always_comb begin
        w_disp_ent         = c_RS_EMPTY;
        w_disp_ent.valid   = 1'b1;
        w_disp_ent.instr   = disp_instr;
        w_disp_ent.ctrl    = disp_ctrl;
        w_disp_ent.rs1_tag = c_RS_TAG_W'(disp_rs1_tag);
        w_disp_ent.rs2_tag = c_RS_TAG_W'(disp_rs2_tag);
        w_disp_ent.rs1_rdy = disp_rs1_rdy;
        w_disp_ent.rs2_rdy = disp_rs2_rdy;
        if (!disp_rs1_rdy && cdb_valid && (w_disp_ent.rs1_tag == w_cdb_tag_ext)) begin
            w_disp_ent.rs1_rdy        = 1'b1;
            w_disp_ent.instr.rs1_data = cdb_data;
        end
        if (!disp_rs2_rdy && cdb_valid && (w_disp_ent.rs2_tag == w_cdb_tag_ext)) begin
            w_disp_ent.rs2_rdy        = 1'b1;
            w_disp_ent.instr.rs2_data = cdb_data;
        end
    end

    // Collapse: slots at or above the issued one take their younger neighbour.
    for (genvar i = 0; i < DEPTH; i++) begin : g_collapse
        if (i < DEPTH - 1) begin : g_shift
            assign w_col[i] = (w_issue && (IDX_W'(i) >= w_sel_idx)) ? w_woken[i+1] : w_woken[i];
        end else begin : g_last
            assign w_col[i] = w_issue ? c_RS_EMPTY : w_woken[i];
        end
    end

    // New entry lands at the first free slot after the collapse.
    always_comb begin
        w_next = w_col;
        if (w_disp_fire) begin
            w_next[w_occ_rem[IDX_W-1:0]] = w_disp_ent;
        end
    end

    // Entry array and occupancy; flush drops everything including this cycle's dispatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= c_RS_EMPTY;
            r_occ <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= c_RS_EMPTY;
            r_occ <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_next[i];
            r_occ <= w_occ_next;
        end
    end

    // Issue register: reload when empty or consumed, otherwise hold stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_valid <= 1'b0;
            r_iss_instr <= '0;
            r_iss_ctrl  <= '0;
        end else if (flush) begin
            r_iss_valid <= 1'b0;
        end else if (w_out_load) begin
            r_iss_valid <= w_issue;
            if (w_issue) begin
                r_iss_instr <= r_ent[w_sel_idx].instr;
                r_iss_ctrl  <= r_ent[w_sel_idx].ctrl;
            end
        end
    end

    assign iss_valid = r_iss_valid;
    assign iss_instr = r_iss_instr;
    assign iss_ctrl  = r_iss_ctrl;
    assign occupancy = r_occ;

    a_occ_max : assert property (@(posedge clk) disable iff (!rst_n)
        r_occ <= OCC_W'(DEPTH));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_issue && (r_occ == '0)));

endmodule
`default_nettype wire

// File: tb/tb_br_rs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_br_rs
//  Description : Self-checking bench for br_rs: queue-based reference model,
//                per-cycle comparison, directed scenarios and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_br_rs;
    import rv32i_types::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic             disp_valid = 1'b0;
    logic             disp_ready;
    ooo_instr_t       disp_instr = '0;
    ctrl_word_t       disp_ctrl = '0;
    logic [TAG_W-1:0] disp_rs1_tag = '0;
    logic [TAG_W-1:0] disp_rs2_tag = '0;
    logic             disp_rs1_rdy = 1'b0;
    logic             disp_rs2_rdy = 1'b0;
    logic             cdb_valid = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [31:0]      cdb_data = '0;
    logic             iss_valid;
    ooo_instr_t       iss_instr;
    ctrl_word_t       iss_ctrl;
    logic             iss_ready = 1'b1;
    logic [$clog2(DEPTH):0] occupancy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    br_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_instr   (disp_instr),
        .disp_ctrl    (disp_ctrl),
        .disp_rs1_tag (disp_rs1_tag),
        .disp_rs2_tag (disp_rs2_tag),
        .disp_rs1_rdy (disp_rs1_rdy),
        .disp_rs2_rdy (disp_rs2_rdy),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .iss_valid    (iss_valid),
        .iss_instr    (iss_instr),
        .iss_ctrl     (iss_ctrl),
        .iss_ready    (iss_ready),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: plain age-ordered queue ----------------
    typedef struct {
        ooo_instr_t       instr;
        ctrl_word_t       ctrl;
        logic [TAG_W-1:0] t1;
        logic [TAG_W-1:0] t2;
        bit               r1;
        bit               r2;
    } m_ent_t;

    m_ent_t q[$];
    m_ent_t m_iss;
    bit     m_iss_valid = 1'b0;
    int     m_sel;
    int     m_pre;
    m_ent_t m_tmp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_iss_valid = 1'b0;
        end else if (flush) begin
            q.delete();
            m_iss_valid = 1'b0;
        end else begin
            m_pre = q.size();
            m_sel = -1;
            for (int k = 0; k < q.size(); k++) begin
                if (q[k].r1 && q[k].r2) begin
                    m_sel = k;
                    break;
                end
            end
            if (!m_iss_valid || iss_ready) begin
                if (m_sel >= 0) begin
                    m_iss = q[m_sel];
                    q.delete(m_sel);
                    m_iss_valid = 1'b1;
                end else begin
                    m_iss_valid = 1'b0;
                end
            end
            if (cdb_valid) begin
                for (int k = 0; k < q.size(); k++) begin
                    m_tmp = q[k];
                    if (!m_tmp.r1 && m_tmp.t1 == cdb_tag) begin
                        m_tmp.r1 = 1'b1;
                        m_tmp.instr.rs1_data = cdb_data;
                    end
                    if (!m_tmp.r2 && m_tmp.t2 == cdb_tag) begin
                        m_tmp.r2 = 1'b1;
                        m_tmp.instr.rs2_data = cdb_data;
                    end
                    q[k] = m_tmp;
                end
            end
            if (disp_valid && m_pre < DEPTH) begin
                m_tmp.instr = disp_instr;
                m_tmp.ctrl  = disp_ctrl;
                m_tmp.t1    = disp_rs1_tag;
                m_tmp.t2    = disp_rs2_tag;
                m_tmp.r1    = disp_rs1_rdy;
                m_tmp.r2    = disp_rs2_rdy;
                if (!m_tmp.r1 && cdb_valid && cdb_tag == m_tmp.t1) begin
                    m_tmp.r1 = 1'b1;
                    m_tmp.instr.rs1_data = cdb_data;
                end
                if (!m_tmp.r2 && cdb_valid && cdb_tag == m_tmp.t2) begin
                    m_tmp.r2 = 1'b1;
                    m_tmp.instr.rs2_data = cdb_data;
                end
                q.push_back(m_tmp);
            end
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("occupancy", 256'(occupancy), 256'(q.size()));
            chk("iss_valid", 256'(iss_valid), 256'(m_iss_valid));
            chk("disp_ready", 256'(disp_ready), 256'((q.size() < DEPTH) && !flush));
            if (m_iss_valid) begin
                chk("iss_instr", 256'(iss_instr), 256'(m_iss.instr));
                chk("iss_ctrl", 256'(iss_ctrl), 256'(m_iss.ctrl));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic drive_disp(input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                              input logic r1, input logic r2);
        disp_valid          = 1'b1;
        disp_instr.pc       = pc;
        disp_instr.imm      = pc ^ 32'h5a;
        disp_instr.opcode   = c_OP_BRANCH;
        disp_instr.rs1_data = d1;
        disp_instr.rs2_data = d2;
        disp_ctrl.cmp_op    = c_F3_BEQ;
        disp_ctrl.is_jump   = 1'b0;
        disp_rs1_tag        = t1;
        disp_rs2_tag        = t2;
        disp_rs1_rdy        = r1;
        disp_rs2_rdy        = r2;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        idle();
        iss_ready = 1'b1;
        repeat (3) tick();
        chk("reset occupancy", 256'(occupancy), 256'(0));
        chk("reset iss_valid", 256'(iss_valid), 256'(0));
        chk("reset disp_ready", 256'(disp_ready), 256'(1));
        rst_n = 1'b1;
        tick();

        // Both operands ready: issues after the second edge.
        drive_disp(32'h40, 32'd5, 32'd5, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        idle();
        chk("beq occupancy after dispatch", 256'(occupancy), 256'(1));
        chk("beq iss_valid early", 256'(iss_valid), 256'(0));
        tick();
        chk("beq iss_valid", 256'(iss_valid), 256'(1));
        chk("beq rs1_data", 256'(iss_instr.rs1_data), 256'(5));
        chk("beq rs2_data", 256'(iss_instr.rs2_data), 256'(5));
        chk("beq occupancy drained", 256'(occupancy), 256'(0));
        tick();

        // Younger ready entry overtakes older waiting one.
        drive_disp(32'h100, 32'd0, 32'd2, 5'd3, 5'd0, 1'b0, 1'b1);
        tick();
        drive_disp(32'h200, 32'd1, 32'd1, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        chk("overtake B pc", 256'(iss_instr.pc), 256'(32'h200));
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'h10;
        tick();
        idle();
        chk("wakeup gap iss_valid", 256'(iss_valid), 256'(0));
        tick();
        chk("wakeup A valid", 256'(iss_valid), 256'(1));
        chk("wakeup A pc", 256'(iss_instr.pc), 256'(32'h100));
        chk("wakeup A rs1_data", 256'(iss_instr.rs1_data), 256'(32'h10));
        tick();

        // Dispatch-time bypass from a same-cycle broadcast.
        drive_disp(32'h300, 32'd0, 32'd9, 5'd7, 5'd0, 1'b0, 1'b1);
        cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_data = 32'hABCD;
        tick();
        idle();
        tick();
        chk("bypass pc", 256'(iss_instr.pc), 256'(32'h300));
        chk("bypass rs1_data", 256'(iss_instr.rs1_data), 256'(32'hABCD));
        tick();

        // Fill with the issue port stalled, then drain in order.
        iss_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_disp(32'h400 + 32'(4 * k), 32'(k), 32'(k), 5'd0, 5'd0, 1'b1, 1'b1);
            tick();
        end
        drive_disp(32'h4F0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        chk("full occupancy", 256'(occupancy), 256'(4));
        chk("full disp_ready", 256'(disp_ready), 256'(0));
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall pc stable", 256'(iss_instr.pc), 256'(32'h400));
            chk("stall valid stable", 256'(iss_valid), 256'(1));
        end
        idle();
        iss_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk("drain pc", 256'(iss_instr.pc), 256'(32'h400 + 32'(4 * k)));
        end
        chk("drain occupancy", 256'(occupancy), 256'(0));
        tick();

        // Flush with dispatch and broadcast in the same cycle.
        iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_disp(32'h600 + 32'(4 * k), 32'd1, 32'd1, 5'd0, 5'd0, 1'b1, 1'b1);
            tick();
        end
        idle();
        chk("pre-flush occupancy", 256'(occupancy), 256'(3));
        drive_disp(32'h500, 32'd2, 32'd2, 5'd1, 5'd0, 1'b1, 1'b1);
        cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_data = 32'h77;
        flush = 1'b1;
        tick();
        idle();
        iss_ready = 1'b1;
        chk("flush occupancy", 256'(occupancy), 256'(0));
        chk("flush iss_valid", 256'(iss_valid), 256'(0));
        tick();
        chk("post-flush iss_valid", 256'(iss_valid), 256'(0));
        tick();

        // Asynchronous reset in the middle of a cycle.
        iss_ready = 1'b0;
        drive_disp(32'h700, 32'd3, 32'd3, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        drive_disp(32'h704, 32'd3, 32'd3, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        idle();
        chk("pre-reset iss_valid", 256'(iss_valid), 256'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("async reset iss_valid", 256'(iss_valid), 256'(0));
        chk("async reset occupancy", 256'(occupancy), 256'(0));
        tick();
        rst_n = 1'b1;
        iss_ready = 1'b1;
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            disp_valid          = ($urandom_range(0, 9) < 6);
            disp_instr.pc       = $urandom;
            disp_instr.imm      = $urandom;
            disp_instr.opcode   = ($urandom_range(0, 3) == 0) ? c_OP_JAL : c_OP_BRANCH;
            disp_instr.rs1_data = $urandom;
            disp_instr.rs2_data = $urandom;
            disp_ctrl.cmp_op    = 3'($urandom_range(0, 7));
            disp_ctrl.is_jump   = 1'($urandom_range(0, 1));
            disp_rs1_tag        = 5'($urandom_range(0, 7));
            disp_rs2_tag        = 5'($urandom_range(0, 7));
            disp_rs1_rdy        = 1'($urandom_range(0, 1));
            disp_rs2_rdy        = 1'($urandom_range(0, 1));
            cdb_valid           = ($urandom_range(0, 9) < 4);
            cdb_tag             = 5'($urandom_range(0, 7));
            cdb_data            = $urandom;
            iss_ready           = ($urandom_range(0, 9) < 7);
            flush               = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle();
        iss_ready = 1'b1;
        repeat (3) tick();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/br_rs.md
BR_RS -- requirements
Module: br_rs

Interface
REQ-001 Parameter: DEPTH, default 4, number of branch reservation-station entries (power of 2, 2..8).
REQ-002 Parameter: TAG_W, default 5, width of a physical-source/ROB tag.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  pipeline flush (mispredict/exception); kills all held and in-flight branches.
REQ-006 disp_valid  input  1  dispatch offers a branch/jump instruction.
REQ-007 disp_ready  output  1  RS can accept; high when occupancy < DEPTH and flush low.
REQ-008 disp_instr  input  ooo_instr_t  dispatched instruction (pc, imm, opcode, rs1_data, rs2_data).
REQ-009 disp_ctrl  input  ctrl_word_t  decoded control word (cmp_op used).
REQ-010 disp_rs1_tag, disp_rs2_tag  input  TAG_W each  source tags.
REQ-011 disp_rs1_rdy, disp_rs2_rdy  input  1 each  source data already valid in disp_instr.
REQ-012 cdb_valid  input  1  common data bus broadcast valid.
REQ-013 cdb_tag  input  TAG_W  broadcast tag.
REQ-014 cdb_data  input  32  broadcast value.
REQ-015 iss_valid  output  1  registered instruction presented to branch FU.
REQ-016 iss_instr  output  ooo_instr_t  instruction with resolved rs1_data/rs2_data.
REQ-017 iss_ctrl  output  ctrl_word_t  matching control word.
REQ-018 iss_ready  input  1  writeback accepts branch FU result this cycle.
REQ-019 occupancy  output  $clog2(DEPTH)+1  valid entry count.

Function
REQ-020 Entries SHALL be held in age order (slot 0 oldest); removal SHALL collapse younger entries toward slot 0 in the same edge.
REQ-021 Dispatch handshake SHALL complete on disp_valid && disp_ready; entry written at first free slot after collapse.
REQ-022 disp_ready SHALL NOT depend on same-cycle issue (no pass-through credit); full RS SHALL drop disp_ready even if issuing.
REQ-023 Each cycle, every valid entry with a non-ready source whose tag equals cdb_tag while cdb_valid SHALL capture cdb_data and mark the source ready.
REQ-024 A dispatching source with rdy=0 and tag matching a same-cycle CDB broadcast SHALL be stored ready with cdb_data (bypass).
REQ-025 Selection SHALL pick the oldest entry with both sources ready; at most one issue per cycle.
REQ-026 Output stage SHALL be a single register: load when empty or iss_ready high; otherwise hold iss_* stable.
REQ-027 Issue latency: entry ready at edge N SHALL appear on iss_valid after edge N+1 minimum; CDB wakeup at edge N SHALL permit iss_valid after edge N+1.
REQ-028 Entries not using rs2 (jal, jalr) SHALL be dispatched with disp_rs2_rdy=1 by dispatch; RS treats them identically.
REQ-029 A CDB broadcast SHALL also update a waiting operand in the output register is not required: output register only ever holds fully ready instructions.
REQ-030 flush SHALL clear all entries, iss_valid and occupancy at next edge; dispatch and CDB in the flush cycle are ignored.
REQ-031 Simultaneous dispatch and issue at occupancy DEPTH-1 SHALL leave occupancy DEPTH-1.
REQ-032 Occupancy SHALL never exceed DEPTH nor underflow; assertions SHALL flag either.

Reset
REQ-033 On rst_n low: all entry valid bits, iss_valid and occupancy 0 immediately; disp_ready 1 after deassertion; payload registers don't-care.
REQ-034 Reset asserted mid-operation SHALL discard all entries with no partial issue.

Structure
REQ-035 ooo_instr_t, ctrl_word_t, branch_f3 constants and an rs_entry_t typedef (instr, ctrl, tags, rdy bits, valid) SHALL live in rv32i_types.
REQ-036 Oldest-ready selection SHALL be a sub-module br_rs_select (priority encoder over ready vector, returns index and found).

Verification
REQ-037 Dispatch beq rs1=rs2=5 both ready, iss_ready=1 -> iss_valid after 2nd edge, rs1_data=rs2_data=5; occupancy back to 0.
REQ-038 Dispatch A (rs1 tag 3 not ready), then B ready -> B issues first; CDB tag 3 data 0x10 -> A issues next with rs1_data=0x10.
REQ-039 Dispatch with rs1 tag 7 not ready while cdb_valid tag 7 data 0xABCD same cycle -> entry stored ready, issues with 0xABCD.
REQ-040 Fill 4 entries, iss_ready=0 -> disp_ready=0, occupancy=4, iss_* stable for 10 cycles; raise iss_ready -> drain in order, one per cycle.
REQ-041 occupancy 3, flush with disp_valid and cdb_valid high -> next cycle occupancy=0, iss_valid=0, nothing issued from dispatched instruction.
REQ-042 Assert rst_n=0 asynchronously mid-cycle with iss_valid=1 -> iss_valid and occupancy drop before next clock edge.
